// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared encodings for the bit-serial arithmetic unit
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/fa.sv
// rtl/fa.sv - 1-bit full adder cell
module fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    // Sum and majority carry of the three input bits.
    always_comb begin
        s  = a ^ b ^ ci;
        co = (a & b) | (ci & (a ^ b));
    end

endmodule

// File: rtl/serial_addsub.sv
// rtl/serial_addsub.sv - bit-serial adder/subtractor with start/done handshake
module serial_addsub
    import arith_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ov
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-1:0] acc;
    logic             carry;
    logic             op;
    logic             fa_s;
    logic             fa_co;
    logic [WIDTH-1:0] acc_next;
    logic             unused_acc_lsb;

    // The single shared full adder always works on the current LSBs.
    fa u_fa (
        .a  (sh_a[0]),
        .b  (sh_b[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    // New sum bit enters from the MSB side; the old LSB falls off.
    always_comb begin
        acc_next       = {fa_s, acc[WIDTH-1:1]};
        unused_acc_lsb = acc[0];
    end

    // Control FSM plus datapath registers; outputs are registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            s     <= '0;
            co    <= 1'b0;
            ov    <= 1'b0;
            cnt   <= '0;
            carry <= 1'b0;
            sh_a  <= '0;
            sh_b  <= '0;
            acc   <= '0;
            op    <= OP_ADD;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        // Subtraction is a + ~b + ~borrow_in.
                        sh_a  <= a;
                        sh_b  <= (sub == OP_SUB) ? ~b : b;
                        carry <= (sub == OP_SUB) ? ~ci : ci;
                        op    <= sub;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    sh_a  <= sh_a >> 1;
                    sh_b  <= sh_b >> 1;
                    carry <= fa_co;
                    acc   <= acc_next;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST_BIT) begin
                        // Carry FF still holds the carry into the MSB here.
                        s     <= acc_next;
                        co    <= (op == OP_SUB) ? ~fa_co : fa_co;
                        ov    <= carry ^ fa_co;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
